// File: rtl/tx_min_frame_padder.sv
// Pads outbound AXI-Stream frames shorter than MIN_BYTES with zero bytes.
// Single registered output stage; input is stalled while pad beats are emitted.
module tx_min_frame_padder #(
  parameter int MIN_BYTES = 60,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk156,
  input  logic                 aresetn,
  input  logic [63:0]          s_axis_tdata,
  input  logic [7:0]           s_axis_tkeep,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic                 s_axis_tready,
  output logic [63:0]          m_axis_tdata,
  output logic [7:0]           m_axis_tkeep,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  input  logic                 m_axis_tready,
  output logic [CNT_WIDTH-1:0] frames_padded
);

  typedef enum logic {ST_PASS, ST_PAD} state_t;

  localparam int LW = 12;
  localparam logic [LW-1:0] MIN_L = LW'(MIN_BYTES);
  localparam logic [LW-1:0] EIGHT = LW'(8);

  state_t               state_q, state_d;
  logic [LW-1:0]        p_q, p_d;
  logic [LW-1:0]        r_q, r_d;
  logic                 flag_q, flag_d;
  logic [63:0]          data_q, data_d;
  logic [7:0]           keep_q, keep_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 user_q, user_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                 load;
  logic                 s_ready;
  logic [LW-1:0]        beat_b;
  logic [LW-1:0]        c_sum;
  logic [LW-1:0]        need;
  logic [63:0]          data_zeroed;

  function automatic logic [7:0] lane_mask(input logic [LW-1:0] n);
    logic [8:0] t;
    t = (9'd1 << n[2:0]) - 9'd1;
    return (n >= EIGHT) ? 8'hFF : t[7:0];
  endfunction

  always_comb begin
    beat_b = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (s_axis_tkeep[i]) beat_b = LW'(i + 1);
    end
    data_zeroed = s_axis_tdata;
    for (int unsigned i = 0; i < 8; i++) begin
      if (LW'(i) >= beat_b) data_zeroed[i*8 +: 8] = '0;
    end
  end

  assign c_sum   = p_q + beat_b;
  assign need    = MIN_L - p_q;
  assign load    = !valid_q || m_axis_tready;
  assign s_ready = aresetn && (state_q == ST_PASS) && load;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    r_d     = r_q;
    flag_d  = flag_q;
    data_d  = data_q;
    keep_d  = keep_q;
    valid_d = valid_q;
    last_d  = last_q;
    user_d  = user_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_PASS: begin
        if (s_axis_tvalid && s_ready) begin
          valid_d = 1'b1;
          data_d  = s_axis_tdata;
          keep_d  = s_axis_tkeep;
          last_d  = s_axis_tlast;
          user_d  = s_axis_tlast & s_axis_tuser;
          if (!s_axis_tlast) begin
            p_d = (c_sum >= MIN_L) ? MIN_L : c_sum;
          end else if (c_sum >= MIN_L) begin
            p_d = '0;
          end else begin
            // Runt tail: this beat carries the first pad bytes; longer shortfalls continue in PAD.
            data_d = data_zeroed;
            keep_d = lane_mask(need);
            cnt_d  = cnt_q + CNT_WIDTH'(1);
            p_d    = '0;
            if (need <= EIGHT) begin
              last_d = 1'b1;
              user_d = s_axis_tuser;
            end else begin
              last_d  = 1'b0;
              user_d  = 1'b0;
              r_d     = need - EIGHT;
              flag_d  = s_axis_tuser;
              state_d = ST_PAD;
            end
          end
        end else if (load) begin
          valid_d = 1'b0;
        end
      end
      ST_PAD: begin
        if (load) begin
          valid_d = 1'b1;
          data_d  = '0;
          keep_d  = lane_mask(r_q);
          if (r_q <= EIGHT) begin
            last_d  = 1'b1;
            user_d  = flag_q;
            state_d = ST_PASS;
            p_d     = '0;
          end else begin
            last_d = 1'b0;
            user_d = 1'b0;
            r_d    = r_q - EIGHT;
          end
        end
      end
      default: state_d = ST_PASS;
    endcase
  end

  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_PASS;
      p_q     <= '0;
      r_q     <= '0;
      flag_q  <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      user_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      r_q     <= r_d;
      flag_q  <= flag_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      user_q  <= user_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tdata  = data_q;
  assign m_axis_tkeep  = keep_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last_q;
  assign m_axis_tuser  = user_q;
  assign frames_padded = cnt_q;

endmodule

// File: tb/tb_tx_min_frame_padder.sv
// Bench for tx_min_frame_padder: directed and random frames checked against a
// byte-level model (pad to MIN bytes, repack into 8-byte beats).
module tb_tx_min_frame_padder;

  localparam int MIN = 60;

  logic        clk156 = 1'b0;
  logic        aresetn;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        m_axis_tready;
  logic [31:0] frames_padded;

  tx_min_frame_padder #(.MIN_BYTES(MIN), .CNT_WIDTH(32)) dut (
    .clk156        (clk156),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_axis_tready),
    .frames_padded (frames_padded)
  );

  always #5 clk156 = ~clk156;

  int tests = 0;
  int fails = 0;
  int exp_padded = 0;
  int rdy_mode = 0;
  logic [73:0] expq[$];

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Downstream ready pattern, changed just after each rising edge.
  always @(posedge clk156) begin
    #1;
    case (rdy_mode)
      1:       m_axis_tready = ~m_axis_tready;
      2:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b1;
    endcase
  end

  logic [73:0] cur;
  logic [73:0] held;
  logic [73:0] expb;
  logic        stalled = 1'b0;
  assign cur = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};

  always @(negedge clk156) begin
    if (!aresetn) begin
      stalled = 1'b0;
    end else begin
      if (stalled) chk("hold_stable", 80'({m_axis_tvalid, cur}), 80'({1'b1, held}));
      if (m_axis_tvalid && m_axis_tready) begin
        stalled = 1'b0;
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL unexpected_beat: got %0h expected none", cur);
        end else begin
          expb = expq.pop_front();
          chk("out_beat", 80'(cur), 80'(expb));
        end
      end else if (m_axis_tvalid) begin
        stalled = 1'b1;
        held = cur;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  function automatic logic [7:0] kmask(input int n);
    return (n >= 8) ? 8'hFF : 8'((1 << n) - 1);
  endfunction

  // Called just after a rising edge; returns how many cycles the first beat waited.
  task automatic send_frame(input int len, input logic user, input bit empty_last, output int stall0);
    logic [7:0]  by[$];
    logic [63:0] d;
    int L, nb, nin, nk, n;
    for (int i = 0; i < len; i++) by.push_back(8'($urandom));
    L = (len < MIN) ? MIN : len;
    if (len < MIN) exp_padded++;
    nb = (L + 7) / 8;
    for (int k = 0; k < nb; k++) begin
      d = '0;
      for (int j = 0; j < 8; j++)
        if (8 * k + j < len) d[j*8 +: 8] = by[8 * k + j];
      expq.push_back({d, kmask(L - 8 * k), k == nb - 1, (k == nb - 1) & user});
    end
    nin = (len + 7) / 8 + (empty_last ? 1 : 0);
    stall0 = 0;
    for (int k = 0; k < nin; k++) begin
      nk = (len - 8 * k > 8) ? 8 : ((len - 8 * k < 0) ? 0 : len - 8 * k);
      d = {$urandom, $urandom};
      for (int j = 0; j < 8; j++)
        if (j < nk) d[j*8 +: 8] = by[8 * k + j];
        else if (len >= MIN) d[j*8 +: 8] = '0;
      s_axis_tdata  = d;
      s_axis_tkeep  = kmask(nk);
      s_axis_tlast  = (k == nin - 1);
      s_axis_tuser  = (k == nin - 1) & user;
      s_axis_tvalid = 1'b1;
      n = 0;
      forever begin
        @(negedge clk156);
        if (s_axis_tready) break;
        n++;
        if (n > 200) begin
          tests++;
          fails++;
          $display("FAIL accept_timeout: got no s_axis_tready expected within 200 cycles");
          $display("[TB] %0d tests run, %0d failed", tests, fails);
          $fatal(1, "stuck");
        end
      end
      if (k == 0) stall0 = n;
      @(posedge clk156);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tkeep  = '0;
    s_axis_tdata  = '0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 1000) begin
      @(posedge clk156);
      #1;
      n++;
    end
    repeat (3) @(posedge clk156);
    #1;
    chk(tag, 80'(expq.size()), 80'(0));
  endtask

  int st;

  initial begin
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    m_axis_tready = 1'b1;
    #2;
    chk("rst_tvalid", 80'(m_axis_tvalid), 80'(0));
    chk("rst_tdata_tkeep", 80'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 80'(0));
    chk("rst_frames", 80'(frames_padded), 80'(0));
    chk("rst_s_ready", 80'(s_axis_tready), 80'(0));
    repeat (2) @(posedge clk156);
    #1 aresetn = 1'b1;
    @(posedge clk156);
    #1;

    send_frame(60, 1'b0, 1'b0, st);
    drain("c1_drain");
    chk("c1_frames", 80'(frames_padded), 80'(exp_padded));

    send_frame(14, 1'b0, 1'b0, st);
    send_frame(60, 1'b0, 1'b0, st);
    chk("c2_pad_stall", 80'(st), 80'(6));
    drain("c2_drain");
    chk("c2_frames", 80'(frames_padded), 80'(1));

    send_frame(1, 1'b0, 1'b0, st);
    drain("c3_drain");

    rdy_mode = 1;
    send_frame(14, 1'b0, 1'b0, st);
    drain("c4_drain");
    rdy_mode = 0;
    @(posedge clk156);
    #1;

    send_frame(14, 1'b1, 1'b0, st);
    send_frame(64, 1'b0, 1'b0, st);
    chk("c5_pad_stall", 80'(st), 80'(6));
    drain("c5_drain");

    send_frame(57, 1'b1, 1'b0, st);
    send_frame(59, 1'b0, 1'b0, st);
    send_frame(61, 1'b1, 1'b0, st);
    send_frame(52, 1'b0, 1'b0, st);
    send_frame(8, 1'b1, 1'b1, st);
    send_frame(0, 1'b0, 1'b1, st);
    send_frame(56, 1'b1, 1'b1, st);
    drain("edge_drain");
    chk("edge_frames", 80'(frames_padded), 80'(exp_padded));

    rdy_mode = 2;
    for (int f = 0; f < 40; f++)
      send_frame(int'($urandom_range(1, 130)), 1'($urandom_range(0, 1)), 1'b0, st);
    drain("rand_drain");
    chk("rand_frames", 80'(frames_padded), 80'(exp_padded));
    rdy_mode = 0;
    @(posedge clk156);
    #1;

    send_frame(14, 1'b0, 1'b0, st);
    repeat (2) @(posedge clk156);
    #1 aresetn = 1'b0;
    #1;
    chk("c6_tvalid", 80'(m_axis_tvalid), 80'(0));
    chk("c6_frames", 80'(frames_padded), 80'(0));
    chk("c6_s_ready", 80'(s_axis_tready), 80'(0));
    expq.delete();
    exp_padded = 0;
    @(posedge clk156);
    #1 aresetn = 1'b1;
    @(posedge clk156);
    #1;
    send_frame(60, 1'b0, 1'b0, st);
    drain("c6_drain");
    chk("c6_frames_after", 80'(frames_padded), 80'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
